// File: rtl/ip_cmx3x3.sv
// ip_cmx3x3: 3x3 signed colour matrix with double-buffered coefficients and a 4-stage pipeline.
// Optional per-channel output offset is enabled with the IP_CMX3_OFFSET_EN macro.
module ip_cmx3x3 #(
    parameter int unsigned CIIW = 8,
    parameter int unsigned CIPW = 6,
    parameter int unsigned COIW = 8,
    parameter int unsigned COPW = 0,
    parameter int unsigned CFW  = 15,
    parameter int unsigned CFPW = 11
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CIIW+CIPW-1:0]          i_data_0,
    input  logic [CIIW+CIPW-1:0]          i_data_1,
    input  logic [CIIW+CIPW-1:0]          i_data_2,
    input  logic                          i_hstr,
    input  logic                          i_href,
    input  logic                          i_hend,
    input  logic [9*CFW-1:0]              i_coef,
    input  logic                          i_coef_upd,
`ifdef IP_CMX3_OFFSET_EN
    input  logic signed [COIW+COPW:0]     i_ofst_0,
    input  logic signed [COIW+COPW:0]     i_ofst_1,
    input  logic signed [COIW+COPW:0]     i_ofst_2,
`endif
    output logic [COIW+COPW-1:0]          o_data_0,
    output logic [COIW+COPW-1:0]          o_data_1,
    output logic [COIW+COPW-1:0]          o_data_2,
    output logic                          o_hstr,
    output logic                          o_href,
    output logic                          o_hend,
    output logic                          o_coef_pend
);

    localparam int unsigned CIW   = CIIW + CIPW;
    localparam int unsigned COW   = COIW + COPW;
    localparam int unsigned SHIFT = CFPW + CIPW - COPW;
    localparam int unsigned PW    = CIW + CFW + 1;
    localparam int unsigned SW    = CIW + CFW + 3;

    localparam logic signed [SW-1:0] RND  = SW'(1) <<< (SHIFT - 1);
    localparam logic signed [SW-1:0] MAXV = SW'((1 << COW) - 1);

    function automatic logic [9*CFW-1:0] ident_m();
        logic [9*CFW-1:0] m;
        m = '0;
        for (int k = 0; k < 3; k++) begin
            m[4*k*CFW +: CFW] = CFW'(1 << CFPW);
        end
        return m;
    endfunction

    localparam logic [9*CFW-1:0] IDENT = ident_m();

    logic [9*CFW-1:0]      shadow_q;
    logic [9*CFW-1:0]      active_q;
    logic                  pend_q;
    logic                  xfer_c;

    logic [CIW-1:0]        d1_q  [3];
    logic [9*CFW-1:0]      cf1_q;
    logic signed [PW-1:0]  p2_q  [9];
    logic signed [SW-1:0]  s3_q  [3];
    logic signed [SW-1:0]  shv   [3];
    logic [COW-1:0]        clmp  [3];
    logic [COW-1:0]        d4_q  [3];
    logic [2:0]            flg_q [4];

`ifdef IP_CMX3_OFFSET_EN
    logic signed [COW:0]   of1_q [3];
    logic signed [COW:0]   of2_q [3];
    logic signed [COW:0]   of3_q [3];
`endif

    // Bank transfer happens outside a line or on the pixel carrying line start.
    assign xfer_c = pend_q & (~i_href | i_hstr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= IDENT;
            active_q <= IDENT;
            pend_q   <= 1'b0;
        end else begin
            if (i_coef_upd) shadow_q <= i_coef;
            if (xfer_c)     active_q <= shadow_q;
            if (i_coef_upd)  pend_q  <= 1'b1;
            else if (xfer_c) pend_q  <= 1'b0;
        end
    end

    // S1 snapshots the shadow on a transfer cycle so that pixel already uses it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) d1_q[k] <= '0;
            cf1_q <= '0;
        end else begin
            d1_q[0] <= i_data_0;
            d1_q[1] <= i_data_1;
            d1_q[2] <= i_data_2;
            cf1_q   <= xfer_c ? shadow_q : active_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) flg_q[k] <= '0;
        end else begin
            flg_q[0] <= {i_hend, i_href, i_hstr};
            for (int k = 1; k < 4; k++) flg_q[k] <= flg_q[k-1];
        end
    end

`ifdef IP_CMX3_OFFSET_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                of1_q[k] <= '0;
                of2_q[k] <= '0;
                of3_q[k] <= '0;
            end
        end else begin
            of1_q[0] <= i_ofst_0;
            of1_q[1] <= i_ofst_1;
            of1_q[2] <= i_ofst_2;
            for (int k = 0; k < 3; k++) begin
                of2_q[k] <= of1_q[k];
                of3_q[k] <= of2_q[k];
            end
        end
    end
`endif

    // S2: unsigned pixels zero-extended into signed products.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) p2_q[i] <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                for (int j = 0; j < 3; j++) begin
                    p2_q[3*k+j] <= PW'($signed({1'b0, d1_q[j]}))
                                 * PW'($signed(cf1_q[(3*k+j)*CFW +: CFW]));
                end
            end
        end
    end

    // S3: row sums with the half-LSB rounding constant folded in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) s3_q[k] <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                s3_q[k] <= SW'(p2_q[3*k]) + SW'(p2_q[3*k+1]) + SW'(p2_q[3*k+2]) + RND;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            shv[k]  = s3_q[k] >>> SHIFT;
`ifdef IP_CMX3_OFFSET_EN
            shv[k]  = shv[k] + SW'(of3_q[k]);
`endif
            clmp[k] = shv[k][COW-1:0];
            if (shv[k] < 0)         clmp[k] = '0;
            else if (shv[k] > MAXV) clmp[k] = MAXV[COW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) d4_q[k] <= '0;
        end else begin
            for (int k = 0; k < 3; k++) d4_q[k] <= clmp[k];
        end
    end

    assign o_data_0    = d4_q[0];
    assign o_data_1    = d4_q[1];
    assign o_data_2    = d4_q[2];
    assign o_hstr      = flg_q[3][0];
    assign o_href      = flg_q[3][1];
    assign o_hend      = flg_q[3][2];
    assign o_coef_pend = pend_q;

endmodule

// File: tb/tb_ip_cmx3x3.sv
// Self-checking bench for ip_cmx3x3: scoreboard of expected pixels keyed by output cycle.
module tb_ip_cmx3x3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [13:0]  i_data_0 = '0, i_data_1 = '0, i_data_2 = '0;
    logic         i_hstr = 1'b0, i_href = 1'b0, i_hend = 1'b0;
    logic [134:0] i_coef = '0;
    logic         i_coef_upd = 1'b0;
`ifdef IP_CMX3_OFFSET_EN
    logic signed [8:0] i_ofst_0 = '0, i_ofst_1 = '0, i_ofst_2 = '0;
`endif
    logic [7:0]   o_data_0, o_data_1, o_data_2;
    logic         o_hstr, o_href, o_hend, o_coef_pend;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ip_cmx3x3 dut (
        .clk(clk), .rst_n(rst_n),
        .i_data_0(i_data_0), .i_data_1(i_data_1), .i_data_2(i_data_2),
        .i_hstr(i_hstr), .i_href(i_href), .i_hend(i_hend),
        .i_coef(i_coef), .i_coef_upd(i_coef_upd),
`ifdef IP_CMX3_OFFSET_EN
        .i_ofst_0(i_ofst_0), .i_ofst_1(i_ofst_1), .i_ofst_2(i_ofst_2),
`endif
        .o_data_0(o_data_0), .o_data_1(o_data_1), .o_data_2(o_data_2),
        .o_hstr(o_hstr), .o_href(o_href), .o_hend(o_hend),
        .o_coef_pend(o_coef_pend)
    );

    typedef struct {
        int         due;
        logic [23:0] d;
        logic [2:0] f;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int ofs = 0;
    logic [134:0] idm, lms, clm, swp, hlf;

    function automatic logic [134:0] mk(input int c00, c01, c02, c10, c11, c12, c20, c21, c22);
        logic [134:0] m;
        int c[9];
        c = '{c00, c01, c02, c10, c11, c12, c20, c21, c22};
        m = '0;
        for (int i = 0; i < 9; i++) m[i*15 +: 15] = 15'(c[i]);
        return m;
    endfunction

    // Reference: exact integer matrix product, round half up, shift, offset, clamp.
    function automatic logic [7:0] mdl(input logic [134:0] m, input int k,
                                       input int a0, input int a1, input int a2, input int of);
        longint s;
        s = longint'($signed(m[(3*k)*15 +: 15])) * a0
          + longint'($signed(m[(3*k+1)*15 +: 15])) * a1
          + longint'($signed(m[(3*k+2)*15 +: 15])) * a2;
        s = ((s + 65536) >>> 17) + of;
        if (s < 0) return 8'd0;
        if (s > 255) return 8'd255;
        return 8'(s);
    endfunction

    task automatic send(input int a0, input int a1, input int a2, input logic [2:0] f,
                        input logic upd, input logic [134:0] nm, input logic [134:0] um);
        exp_t e;
        @(posedge clk);
        #1;
        i_data_0 = 14'(a0);
        i_data_1 = 14'(a1);
        i_data_2 = 14'(a2);
        {i_hend, i_href, i_hstr} = f;
        i_coef_upd = upd;
        if (upd) i_coef = nm;
`ifdef IP_CMX3_OFFSET_EN
        i_ofst_0 = 9'(ofs);
        i_ofst_1 = 9'(ofs);
        i_ofst_2 = 9'(ofs);
`endif
        e.due = cyc + 4;
        e.d   = {mdl(um, 2, a0, a1, a2, ofs), mdl(um, 1, a0, a1, a2, ofs), mdl(um, 0, a0, a1, a2, ofs)};
        e.f   = f;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            {i_hend, i_href, i_hstr} = 3'b000;
            i_coef_upd = 1'b0;
        end
    endtask

    task automatic load_idle(input logic [134:0] m);
        @(posedge clk);
        #1;
        {i_hend, i_href, i_hstr} = 3'b000;
        i_coef = m;
        i_coef_upd = 1'b1;
        idle(3);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_data_0 = 14'd6400;
        i_href = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({o_data_2, o_data_1, o_data_0, o_hend, o_href, o_hstr, o_coef_pend} !== 28'd0) begin
            errors++;
            $display("FAIL reset outputs got %h want 0",
                     {o_data_2, o_data_1, o_data_0, o_hend, o_href, o_hstr, o_coef_pend});
        end
        i_href = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_identity();
        exp_t e;
        fork
            begin
                send(6400, 6400, 6400, 3'b011, 1'b0, idm, idm);
                send(32, 31, 16383, 3'b010, 1'b0, idm, idm);
                send(8160, 100, 12345, 3'b010, 1'b0, idm, idm);
                send(0, 0, 0, 3'b110, 1'b0, idm, idm);
                send(1000, 2000, 3000, 3'b000, 1'b0, idm, idm);
            end
            begin
                repeat (11) begin
                    @(negedge clk);
                    if (sb.size() > 0 && sb[0].due == cyc) begin
                        e = sb.pop_front();
                        checks++;
                        if ({o_data_2, o_data_1, o_data_0, o_hend, o_href, o_hstr} !== {e.d, e.f}) begin
                            errors++;
                            $display("FAIL identity cyc %0d got %h want %h", cyc,
                                     {o_data_2, o_data_1, o_data_0, o_hend, o_href, o_hstr}, {e.d, e.f});
                        end
                    end
                end
            end
        join
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL identity timeout pending %0d want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_lms();
        exp_t e;
        load_idle(lms);
        fork
            begin
                send(16320, 16320, 16320, 3'b011, 1'b0, idm, lms);
                for (int i = 0; i < 5; i++)
                    send(int'($urandom_range(0, 16383)), int'($urandom_range(0, 16383)),
                         int'($urandom_range(0, 16383)), 3'b010, 1'b0, idm, lms);
                send(16320, 0, 16320, 3'b110, 1'b0, idm, lms);
                send(0, 16383, 0, 3'b000, 1'b0, idm, lms);
            end
            begin
                repeat (14) begin
                    @(negedge clk);
                    if (sb.size() > 0 && sb[0].due == cyc) begin
                        e = sb.pop_front();
                        checks++;
                        if ({o_data_2, o_data_1, o_data_0, o_hend, o_href, o_hstr} !== {e.d, e.f}) begin
                            errors++;
                            $display("FAIL lms cyc %0d got %h want %h", cyc,
                                     {o_data_2, o_data_1, o_data_0, o_hend, o_href, o_hstr}, {e.d, e.f});
                        end
                    end
                end
            end
        join
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL lms timeout pending %0d want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_clamp();
        exp_t e;
        load_idle(clm);
        fork
            begin
                send(12800, 0, 6400, 3'b011, 1'b0, idm, clm);
                send(8160, 0, 0, 3'b010, 1'b0, idm, clm);
                send(8176, 0, 16383, 3'b010, 1'b0, idm, clm);
                send(8128, 0, 32, 3'b010, 1'b0, idm, clm);
                send(16383, 16383, 16383, 3'b010, 1'b0, idm, clm);
`ifdef IP_CMX3_OFFSET_EN
                ofs = 5;
                send(0, 0, 0, 3'b010, 1'b0, idm, clm);
                ofs = -3;
                send(6400, 0, 6400, 3'b010, 1'b0, idm, clm);
                ofs = 0;
`endif
                send(0, 0, 0, 3'b110, 1'b0, idm, clm);
            end
            begin
                repeat (14) begin
                    @(negedge clk);
                    if (sb.size() > 0 && sb[0].due == cyc) begin
                        e = sb.pop_front();
                        checks++;
                        if ({o_data_2, o_data_1, o_data_0, o_hend, o_href, o_hstr} !== {e.d, e.f}) begin
                            errors++;
                            $display("FAIL clamp cyc %0d got %h want %h", cyc,
                                     {o_data_2, o_data_1, o_data_0, o_hend, o_href, o_hstr}, {e.d, e.f});
                        end
                    end
                end
            end
        join
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL clamp timeout pending %0d want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_mid_line_update();
        exp_t e;
        fork
            begin
                send(6400, 3200, 1600, 3'b011, 1'b0, idm, clm);
                send(6400, 3200, 1600, 3'b010, 1'b1, swp, clm);
                send(6400, 3200, 1600, 3'b010, 1'b0, idm, clm);
                checks++;
                if (o_coef_pend !== 1'b1) begin
                    errors++;
                    $display("FAIL mid_pend_rise got %b want 1", o_coef_pend);
                end
                send(6400, 3200, 1600, 3'b110, 1'b0, idm, clm);
                send(6400, 3200, 1600, 3'b011, 1'b0, idm, swp);
                checks++;
                if (o_coef_pend !== 1'b1) begin
                    errors++;
                    $display("FAIL mid_pend_hold got %b want 1", o_coef_pend);
                end
                send(6400, 3200, 1600, 3'b010, 1'b0, idm, swp);
                checks++;
                if (o_coef_pend !== 1'b0) begin
                    errors++;
                    $display("FAIL mid_pend_fall got %b want 0", o_coef_pend);
                end
                send(6400, 3200, 1600, 3'b000, 1'b0, idm, swp);
            end
            begin
                repeat (13) begin
                    @(negedge clk);
                    if (sb.size() > 0 && sb[0].due == cyc) begin
                        e = sb.pop_front();
                        checks++;
                        if ({o_data_2, o_data_1, o_data_0, o_hend, o_href, o_hstr} !== {e.d, e.f}) begin
                            errors++;
                            $display("FAIL mid_line cyc %0d got %h want %h", cyc,
                                     {o_data_2, o_data_1, o_data_0, o_hend, o_href, o_hstr}, {e.d, e.f});
                        end
                    end
                end
            end
        join
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL mid_line timeout pending %0d want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        fork
            begin
                send(6400, 3200, 1600, 3'b011, 1'b0, idm, swp);
                send(6400, 3200, 1600, 3'b010, 1'b1, lms, swp);
                send(6400, 3200, 1600, 3'b010, 1'b1, hlf, swp);
                send(6400, 3200, 1600, 3'b110, 1'b0, idm, swp);
                checks++;
                if (o_coef_pend !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_pend_hold got %b want 1", o_coef_pend);
                end
                send(6400, 3200, 1600, 3'b011, 1'b0, idm, hlf);
                send(6400, 3200, 1600, 3'b010, 1'b0, idm, hlf);
                checks++;
                if (o_coef_pend !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_pend_fall got %b want 0", o_coef_pend);
                end
                send(6400, 3200, 1600, 3'b000, 1'b0, idm, hlf);
            end
            begin
                repeat (13) begin
                    @(negedge clk);
                    if (sb.size() > 0 && sb[0].due == cyc) begin
                        e = sb.pop_front();
                        checks++;
                        if ({o_data_2, o_data_1, o_data_0, o_hend, o_href, o_hstr} !== {e.d, e.f}) begin
                            errors++;
                            $display("FAIL back_to_back cyc %0d got %h want %h", cyc,
                                     {o_data_2, o_data_1, o_data_0, o_hend, o_href, o_hstr}, {e.d, e.f});
                        end
                    end
                end
            end
        join
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL back_to_back timeout pending %0d want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        send(6400, 6400, 6400, 3'b011, 1'b0, idm, hlf);
        send(6400, 6400, 6400, 3'b010, 1'b1, lms, hlf);
        send(6400, 6400, 6400, 3'b010, 1'b0, idm, hlf);
        send(6400, 6400, 6400, 3'b010, 1'b0, idm, hlf);
        send(6400, 6400, 6400, 3'b010, 1'b0, idm, hlf);
        checks++;
        if (o_coef_pend !== 1'b1 || o_href !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset pend/href got %b%b want 11", o_coef_pend, o_href);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_data_2, o_data_1, o_data_0, o_hend, o_href, o_hstr, o_coef_pend} !== 28'd0) begin
            errors++;
            $display("FAIL async_reset got %h want 0",
                     {o_data_2, o_data_1, o_data_0, o_hend, o_href, o_hstr, o_coef_pend});
        end
        sb.delete();
        {i_hend, i_href, i_hstr} = 3'b000;
        i_coef_upd = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        fork
            begin
                send(6400, 6400, 6400, 3'b011, 1'b0, idm, idm);
                send(6400, 3200, 1600, 3'b110, 1'b0, idm, idm);
                send(0, 0, 0, 3'b000, 1'b0, idm, idm);
            end
            begin
                repeat (9) begin
                    @(negedge clk);
                    if (sb.size() > 0 && sb[0].due == cyc) begin
                        e = sb.pop_front();
                        checks++;
                        if ({o_data_2, o_data_1, o_data_0, o_hend, o_href, o_hstr} !== {e.d, e.f}) begin
                            errors++;
                            $display("FAIL post_reset cyc %0d got %h want %h", cyc,
                                     {o_data_2, o_data_1, o_data_0, o_hend, o_href, o_hstr}, {e.d, e.f});
                        end
                    end
                end
            end
        join
        checks++;
        if (sb.size() != 0 || o_coef_pend !== 1'b0) begin
            errors++;
            $display("FAIL post_reset pending %0d pend %b want 0 0", sb.size(), o_coef_pend);
            sb.delete();
        end
    endtask

    initial begin
        idm = mk(2048, 0, 0, 0, 2048, 0, 0, 0, 2048);
        lms = mk(8349, -6774, 473, -2598, 5345, -699, -9, -1441, 3497);
        clm = mk(-2048, 0, 0, 4096, 0, 0, 0, 0, 2048);
        swp = mk(0, 2048, 0, 0, 0, 2048, 2048, 0, 0);
        hlf = mk(1024, 0, 0, 0, 1024, 0, 0, 0, 1024);
        test_reset();
        test_identity();
        test_lms();
        test_clamp();
        test_mid_line_update();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
